// File: rtl/sdma_pkg.sv
// Shared types for the SDMA burst controller: FSM state encoding, stats width
// and the level-width helper.
package sdma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2,
      ST_IRQ  = 2'd3
   } sdma_state_e;

   localparam int STAT_W = 16;

   // One extra bit so a full FIFO (level == depth) is representable.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sdma_sync_fifo.sv
// Synchronous FIFO with wrap-bit counters, registered read data and an
// overflow event strobe for pushes dropped while full.
module sdma_sync_fifo
   import sdma_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 64,
   parameter int LVL_W = lvl_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [DW-1:0]    wdata_i,
   output logic [DW-1:0]    rdata_o,
   output logic [LVL_W-1:0] level_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             ovf_evt_o
);

   localparam int AW = $clog2(DEPTH);

   logic [LVL_W-1:0] wr_cnt_q, rd_cnt_q;
   logic [DW-1:0]    rdata_q;
   logic [DW-1:0]    mem_q [DEPTH];
   logic             do_push, do_pop;

   assign level_o = wr_cnt_q - rd_cnt_q;
   assign full_o  = (level_o == LVL_W'(DEPTH));
   assign empty_o = (level_o == '0);

   // A pop frees a slot in the same cycle, so a push at full still lands.
   assign do_pop    = pop_i & ~empty_o;
   assign do_push   = push_i & (~full_o | do_pop);
   assign ovf_evt_o = push_i & full_o & ~do_pop;
   assign rdata_o   = rdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         rdata_q  <= '0;
      end else begin
         if (do_push) wr_cnt_q <= wr_cnt_q + 1'b1;
         if (do_pop) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
            rdata_q  <= mem_q[rd_cnt_q[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_cnt_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/sdma_burst_ctrl.sv
// Buffers fabric samples and requests an SDMA burst once BURST_LEN words are
// queued; optional burst/drop counters are enabled with SDMA_BURST_STATS_EN.
module sdma_burst_ctrl
   import sdma_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int FIFO_DEPTH = 64,
   parameter  int BURST_LEN  = 16,
   localparam int LVL_W      = lvl_w(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  valid,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  sdma_req,
   input  logic                  sdma_active,
   input  logic                  sdma_done,
   output logic                  sdma_irq,
   output logic [LVL_W-1:0]      level,
   output logic                  overflow,
   input  logic                  clr_ovf
`ifdef SDMA_BURST_STATS_EN
   ,
   output logic [STAT_W-1:0]     burst_cnt,
   output logic [STAT_W-1:0]     drop_cnt
`endif
);

   sdma_state_e state_q;
   logic        sdma_req_q, sdma_irq_q;
   logic        overflow_q, overflow_d;
   logic        ovf_evt, fifo_full, fifo_empty;

   sdma_sync_fifo #(
      .DW    (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (valid),
      .pop_i     (rd_en),
      .wdata_i   (data),
      .rdata_o   (rd_data),
      .level_o   (level),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .ovf_evt_o (ovf_evt)
   );

   // A drop in the same cycle as a clear keeps the flag set.
   assign overflow_d = ovf_evt | (overflow_q & ~clr_ovf);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) overflow_q <= 1'b0;
      else      overflow_q <= overflow_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         sdma_req_q <= 1'b0;
         sdma_irq_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sdma_irq_q <= 1'b0;
               if (enable && (level >= LVL_W'(BURST_LEN))) begin
                  state_q    <= ST_REQ;
                  sdma_req_q <= 1'b1;
               end
            end
            ST_REQ: begin
               // done alongside active is not a completion; only advance.
               if (sdma_active) begin
                  state_q    <= ST_XFER;
                  sdma_req_q <= 1'b0;
               end
            end
            ST_XFER: begin
               if (sdma_done) begin
                  state_q    <= ST_IRQ;
                  sdma_irq_q <= 1'b1;
               end
            end
            ST_IRQ: begin
               state_q    <= ST_IDLE;
               sdma_irq_q <= 1'b0;
            end
            default: begin
               state_q    <= ST_IDLE;
               sdma_req_q <= 1'b0;
               sdma_irq_q <= 1'b0;
            end
         endcase
      end
   end

   assign sdma_req = sdma_req_q;
   assign sdma_irq = sdma_irq_q;
   assign overflow = overflow_q;

`ifdef SDMA_BURST_STATS_EN
   logic [STAT_W-1:0] burst_cnt_q, drop_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         burst_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (state_q == ST_XFER && sdma_done && burst_cnt_q != '1)
            burst_cnt_q <= burst_cnt_q + 1'b1;
         if (ovf_evt && drop_cnt_q != '1)
            drop_cnt_q <= drop_cnt_q + 1'b1;
      end
   end

   assign burst_cnt = burst_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`endif

endmodule
